// File: rtl/c6502_bus_ctrl.sv
// c6502_bus_ctrl: paces the c6502 core via cpu_ce and bridges each core bus cycle to a req/ack memory port.
// Optional macro BUS_ROM_PROTECT_EN: writes at or above ROM_BASE are dropped without touching memory.
module c6502_bus_ctrl #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [15:0] ROM_BASE = 16'hC000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_out,
    input  logic        cpu_we,
    output logic [7:0]  cpu_in,
    output logic        cpu_ce,
    input  logic        halt,
    output logic        halted,
    output logic [15:0] mem_address,
    output logic [7:0]  mem_wdata,
    output logic        mem_req,
    output logic        mem_wr,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        bus_err,
    output logic [15:0] cycles
);
    typedef enum logic [1:0] {IDLE, WAIT, STEP, HALT} state_t;

    state_t     state, state_nxt;
    logic [7:0] wait_cnt;
    logic       rom_skip;
    logic       rom_hit;
    logic       timeout_hit;

`ifdef BUS_ROM_PROTECT_EN
    assign rom_hit = cpu_we && (cpu_address >= ROM_BASE);
`else
    logic unused_rom_base;
    assign unused_rom_base = ^ROM_BASE;
    assign rom_hit = 1'b0;
`endif

    assign timeout_hit = (wait_cnt == 8'(TIMEOUT - 1));
    assign cpu_ce      = (state == STEP);
    assign halted      = (state == HALT);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state; a suppressed ROM write spends exactly one clock in WAIT
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = halt ? HALT : WAIT;
            WAIT: state_nxt = (rom_skip || mem_ack || timeout_hit) ? STEP : WAIT;
            STEP: state_nxt = IDLE;
            HALT: state_nxt = halt ? HALT : IDLE;
        endcase
    end

    // Transaction datapath: capture the core cycle, finish on ack or timeout, count completed steps
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_address <= 16'h0000;
            mem_wdata   <= 8'h00;
            mem_wr      <= 1'b0;
            mem_req     <= 1'b0;
            rom_skip    <= 1'b0;
            wait_cnt    <= 8'h00;
            cpu_in      <= 8'h00;
            bus_err     <= 1'b0;
            cycles      <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (!halt) begin
                        mem_address <= cpu_address;
                        mem_wdata   <= cpu_out;
                        mem_wr      <= cpu_we;
                        mem_req     <= !rom_hit;
                        rom_skip    <= rom_hit;
                        wait_cnt    <= 8'h00;
                    end
                end
                WAIT: begin
                    if (rom_skip) begin
                        rom_skip <= 1'b0;
                    end else if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_wr)
                            cpu_in <= mem_rdata;
                    end else if (timeout_hit) begin
                        mem_req <= 1'b0;
                        bus_err <= 1'b1;
                        if (!mem_wr)
                            cpu_in <= 8'hFF;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                STEP: cycles <= cycles + 16'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_c6502_bus_ctrl.sv
// tb_c6502_bus_ctrl: randomized core/memory stimulus checked against a transaction-level model of the bus controller.
module tb_c6502_bus_ctrl;
    localparam int TIMEOUT = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] cpu_address;
    logic [7:0]  cpu_out;
    logic        cpu_we;
    logic [7:0]  cpu_in;
    logic        cpu_ce;
    logic        halt;
    logic        halted;
    logic [15:0] mem_address;
    logic [7:0]  mem_wdata;
    logic        mem_req;
    logic        mem_wr;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        bus_err;
    logic [15:0] cycles;

    c6502_bus_ctrl #(.TIMEOUT(TIMEOUT), .ROM_BASE(16'hC000)) dut (
        .clock(clock), .reset(reset),
        .cpu_address(cpu_address), .cpu_out(cpu_out), .cpu_we(cpu_we), .cpu_in(cpu_in), .cpu_ce(cpu_ce),
        .halt(halt), .halted(halted),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_req(mem_req), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .bus_err(bus_err), .cycles(cycles)
    );

    always #5 clock = ~clock;

    logic [7:0]  mem   [0:65535];
    logic [7:0]  model [0:65535];
    logic [7:0]  exp_in;
    logic        exp_err;
    logic [15:0] exp_cycles;
    bit          rom_prot;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // One core step starting at an IDLE negedge; delay = WAIT clock carrying the ack (> TIMEOUT means none)
    task automatic step(input logic [15:0] addr, input logic [7:0] data, input logic we, input int delay, input bit hflag);
        bit prot;
        int len;
        int n;
        int exp_len;
        prot = rom_prot && we && (addr >= 16'hC000);
        exp_len = prot ? 0 : (delay <= TIMEOUT ? delay : TIMEOUT);
        cpu_address = addr;
        cpu_out = data;
        cpu_we = we;
        @(negedge clock);
        check("req_seen", mem_req, !prot);
        if (!prot) begin
            check("addr", mem_address, addr);
            check("wr", mem_wr, we);
            if (we)
                check("wdata", mem_wdata, data);
        end
        len = 0;
        n = 0;
        while (!cpu_ce && n < 300) begin
            mem_rdata = 8'($urandom);
            if (mem_req) begin
                len++;
                mem_ack = (len == delay);
                if (mem_ack && mem_wr)
                    mem[mem_address] = mem_wdata;
                if (mem_ack && !mem_wr)
                    mem_rdata = mem[mem_address];
            end
            if (hflag && n == 0)
                halt = 1'b1;
            @(negedge clock);
            mem_ack = 1'b0;
            n++;
        end
        if (!prot && delay <= TIMEOUT && we)
            model[addr] = data;
        if (!prot && !we)
            exp_in = (delay <= TIMEOUT) ? model[addr] : 8'hFF;
        if (!prot && delay > TIMEOUT)
            exp_err = 1'b1;
        exp_cycles = exp_cycles + 16'd1;
        check("ce", cpu_ce, 1'b1);
        check("wait_clks", n, prot ? 1 : exp_len);
        check("req_len", len, exp_len);
        check("cpu_in", cpu_in, exp_in);
        @(negedge clock);
        check("ce_low", cpu_ce, 1'b0);
        check("cycles", cycles, exp_cycles);
        check("bus_err", bus_err, exp_err);
        if (hflag) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clock);
                check("halted", halted, 1'b1);
                check("halt_noreq", mem_req, 1'b0);
                check("halt_noce", cpu_ce, 1'b0);
            end
            halt = 1'b0;
            @(negedge clock);
            check("resume", halted, 1'b0);
            check("resume_noreq", mem_req, 1'b0);
        end
    endtask

    // Reset pulsed mid-WAIT, then a stray ack while the controller is parked
    task automatic reset_mid_wait();
        cpu_address = 16'h0020;
        cpu_we = 1'b0;
        @(negedge clock);
        check("rst_pre_req", mem_req, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("rst_req", mem_req, 1'b0);
        check("rst_ce", cpu_ce, 1'b0);
        check("rst_in", cpu_in, 8'h00);
        check("rst_err", bus_err, 1'b0);
        check("rst_cycles", cycles, 16'h0000);
        check("rst_addr", mem_address, 16'h0000);
        halt = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 8'h77;
        @(negedge clock);
        mem_ack = 1'b0;
        check("stray_halted", halted, 1'b1);
        check("stray_ce", cpu_ce, 1'b0);
        check("stray_in", cpu_in, 8'h00);
        halt = 1'b0;
        @(negedge clock);
        exp_in = 8'h00;
        exp_err = 1'b0;
        exp_cycles = 16'h0000;
        check("post_rst_cycles", cycles, 16'h0000);
    endtask

    initial begin
        logic [15:0] a;
        int r;
        int d;
`ifdef BUS_ROM_PROTECT_EN
        rom_prot = 1'b1;
`else
        rom_prot = 1'b0;
`endif
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'(i * 7 + 3);
            model[i] = 8'(i * 7 + 3);
        end
        mem[0] = 8'hA9;
        model[0] = 8'hA9;
        exp_in = 8'h00;
        exp_err = 1'b0;
        exp_cycles = 16'h0000;
        reset = 1'b1;
        cpu_address = 16'h0000;
        cpu_out = 8'h00;
        cpu_we = 1'b0;
        halt = 1'b0;
        mem_rdata = 8'h00;
        mem_ack = 1'b0;
        repeat (2) @(negedge clock);
        check("reset_req", mem_req, 1'b0);
        check("reset_ce", cpu_ce, 1'b0);
        check("reset_in", cpu_in, 8'h00);
        check("reset_cycles", cycles, 16'h0000);
        check("reset_err", bus_err, 1'b0);
        reset = 1'b0;
        @(negedge clock);
        step(16'h0000, 8'h00, 1'b0, 1, 1'b0);
        step(16'h0200, 8'h5A, 1'b1, 4, 1'b0);
        check("mem_written", mem[16'h0200], 8'h5A);
        step(16'h0200, 8'h00, 1'b0, 2, 1'b0);
        step(16'h0300, 8'h11, 1'b1, TIMEOUT, 1'b0);
        step(16'h0010, 8'h00, 1'b0, 40, 1'b0);
        step(16'h0011, 8'h00, 1'b0, 2, 1'b0);
        step(16'h0012, 8'h00, 1'b0, 3, 1'b1);
        step(16'hC123, 8'h66, 1'b1, 2, 1'b0);
        step(16'hC123, 8'h00, 1'b0, 1, 1'b0);
        step(16'hBFFF, 8'h99, 1'b1, 2, 1'b0);
        check("bfff_written", mem[16'hBFFF], 8'h99);
        reset_mid_wait();
        step(16'h0001, 8'h00, 1'b0, 1, 1'b0);
        for (int k = 0; k < 200; k++) begin
            r = $urandom_range(0, 9);
            a = (r < 5) ? 16'($urandom_range(0, 31)) : (r == 5 ? 16'hBFFF : (r == 6 ? 16'hC000 : 16'($urandom)));
            r = $urandom_range(0, 9);
            d = (r < 6) ? $urandom_range(1, 4) : (r == 6 ? TIMEOUT : (r == 7 ? TIMEOUT - 1 : (r == 8 ? TIMEOUT + 1 : $urandom_range(1, TIMEOUT + 3))));
            step(a, 8'($urandom), 1'($urandom), d, $urandom_range(0, 7) == 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
